// File: rtl/spike_mac_acc_pkg.sv
// Shared widths and state encoding for the DPE spike MAC datapath.
package DPE_params;

  localparam int OUT_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } spike_mac_state_t;

endpackage

// File: rtl/spike_mac_acc_row_picker.sv
// Lowest-set-bit encoder: index, one-hot and none flag; purely combinational.
module spike_row_picker
  import DPE_params::*;
#(
  parameter int N_IN = 8,
  localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic [N_IN-1:0] mask,
  output logic [IW-1:0]   idx,
  output logic [N_IN-1:0] onehot,
  output logic            none
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
  end

  assign onehot = mask & (~mask + N_IN'(1));
  assign none   = ~|mask;

endmodule

// File: rtl/spike_mac_acc.sv
// Sequential spike MAC: one set spike bit per cycle into saturating column sums, k=max(1,popcount) cycles per vector.
// Accepts a vector only in IDLE; column sums are held on out_valid until out_ready, then cleared.
module spike_mac_acc
  import DPE_params::*;
#(
  parameter int N_IN      = 8,
  parameter int N_OUT     = 8,
  parameter int W_WIDTH   = 8,
  parameter int OUT_WIDTH = DPE_params::OUT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       w_we,
  input  logic [$clog2(N_IN)-1:0]    w_row,
  input  logic [N_OUT*W_WIDTH-1:0]   w_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0]            in_spikes,
  input  logic                       in_last,
  input  logic                       abort,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_OUT*OUT_WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]           out_sat
);

  localparam int IW = $clog2(N_IN);

  spike_mac_state_t state_q, state_d;

  logic [W_WIDTH-1:0]         wgt_q [N_IN][N_OUT];
  logic [N_IN-1:0]            pend_q, pend_d;
  logic                       last_q, last_d;
  logic [N_OUT*OUT_WIDTH-1:0] acc_q, add_val;
  logic [N_OUT-1:0]           sat_q, add_ovf;
  logic                       acc_clr, do_add;

  logic [IW-1:0]   pick_idx;
  logic [N_IN-1:0] pick_onehot;
  logic            pick_none;

  spike_row_picker #(.N_IN(N_IN)) u_picker (
    .mask   (pend_q),
    .idx    (pick_idx),
    .onehot (pick_onehot),
    .none   (pick_none)
  );

  // One extra bit per column exposes the carry used for saturation.
  for (genvar j = 0; j < N_OUT; j++) begin : g_col
    logic [OUT_WIDTH:0] sum;
    assign sum = {1'b0, acc_q[j*OUT_WIDTH +: OUT_WIDTH]} + (OUT_WIDTH+1)'(wgt_q[pick_idx][j]);
    assign add_val[j*OUT_WIDTH +: OUT_WIDTH] = sum[OUT_WIDTH] ? {OUT_WIDTH{1'b1}} : sum[OUT_WIDTH-1:0];
    assign add_ovf[j] = sum[OUT_WIDTH];
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_data  = acc_q;
  assign out_sat   = sat_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    last_d  = last_q;
    acc_clr = 1'b0;
    do_add  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = SCAN;
          pend_d  = in_spikes;
          last_d  = in_last;
        end
      end
      SCAN: begin
        do_add = !pick_none;
        pend_d = pend_q & ~pick_onehot;
        // Leave once the bit consumed this cycle was the last one (or there were none).
        if (pend_d == '0) state_d = last_q ? OUT : IDLE;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      pend_d  = '0;
      last_d  = 1'b0;
      acc_clr = 1'b1;
      do_add  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      sat_q   <= '0;
      for (int i = 0; i < N_IN; i++)
        for (int j = 0; j < N_OUT; j++)
          wgt_q[i][j] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      if (acc_clr) begin
        acc_q <= '0;
        sat_q <= '0;
      end else if (do_add) begin
        acc_q <= add_val;
        sat_q <= sat_q | add_ovf;
      end
      if (w_we) begin
        for (int j = 0; j < N_OUT; j++)
          wgt_q[w_row][j] <= w_data[j*W_WIDTH +: W_WIDTH];
      end
    end
  end

endmodule
